// File: rtl/izhikevich_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: walks every neuron once per
// timestep, handing its (v, w) state to a shared update datapath and committing results.
module izhikevich_scheduler #(
  parameter int N           = 32,
  parameter int Q           = 16,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_start,
  input  logic             init_we,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [N-1:0]     init_v,
  input  logic [N-1:0]     init_w,
  output logic             dp_req,
  output logic [IDX_W-1:0] dp_idx,
  output logic [N-1:0]     dp_v,
  output logic [N-1:0]     dp_w,
  input  logic             dp_ack,
  input  logic [N-1:0]     dp_new_v,
  input  logic [N-1:0]     dp_new_w,
  input  logic             dp_spike,
  output logic             busy,
  output logic             step_done,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic [IDX_W:0]   spike_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  if (Q < 0 || Q > N || NUM_NEURONS < 2 || NUM_NEURONS > 256 ||
      IDX_W != $clog2(NUM_NEURONS)) begin : g_param_check
    $error("izhikevich_scheduler: inconsistent parameters");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [N-1:0]     cap_v_q, cap_v_d, cap_w_q, cap_w_d;
  logic             cap_spk_q, cap_spk_d;
  logic             dp_req_q, dp_req_d;
  logic [IDX_W-1:0] dp_idx_q, dp_idx_d;
  logic [N-1:0]     dp_v_q, dp_v_d, dp_w_q, dp_w_d;
  logic             spike_valid_q, spike_valid_d;
  logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
  logic [IDX_W:0]   spike_count_q, spike_count_d;
  logic             step_done_q, step_done_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     v_mem_q [NUM_NEURONS];
  logic [N-1:0]     v_mem_d [NUM_NEURONS];
  logic [N-1:0]     w_mem_q [NUM_NEURONS];
  logic [N-1:0]     w_mem_d [NUM_NEURONS];
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W:0]   cnt_inc;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign cnt_inc = cnt_q + (IDX_W + 1)'(cap_spk_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    cap_v_d       = cap_v_q;
    cap_w_d       = cap_w_q;
    cap_spk_d     = cap_spk_q;
    dp_req_d      = dp_req_q;
    dp_idx_d      = dp_idx_q;
    dp_v_d        = dp_v_q;
    dp_w_d        = dp_w_q;
    spike_valid_d = 1'b0;
    spike_idx_d   = spike_idx_q;
    spike_count_d = spike_count_q;
    step_done_d   = 1'b0;
    v_mem_d       = v_mem_q;
    w_mem_d       = w_mem_q;

    unique case (state_q)
      IDLE: begin
        if (init_we) begin
          v_mem_d[init_idx] = init_v;
          w_mem_d[init_idx] = init_w;
        end
        // Operands come from the post-write view so a same-cycle init is seen.
        if (step_start) begin
          state_d  = ISSUE;
          idx_d    = '0;
          cnt_d    = '0;
          dp_req_d = 1'b1;
          dp_idx_d = '0;
          dp_v_d   = v_mem_d[0];
          dp_w_d   = w_mem_d[0];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (dp_ack) begin
          state_d       = WRITE;
          cap_v_d       = dp_new_v;
          cap_w_d       = dp_new_w;
          cap_spk_d     = dp_spike;
          dp_req_d      = 1'b0;
          spike_valid_d = dp_spike;
          if (dp_spike) spike_idx_d = idx_q;
        end
      end
      WRITE: begin
        v_mem_d[idx_q] = cap_v_q;
        w_mem_d[idx_q] = cap_w_q;
        cnt_d          = cnt_inc;
        if (idx_q == LAST_IDX) begin
          state_d       = DONE;
          step_done_d   = 1'b1;
          spike_count_d = cnt_inc;
        end else begin
          state_d  = ISSUE;
          idx_d    = idx_nxt;
          dp_req_d = 1'b1;
          dp_idx_d = idx_nxt;
          dp_v_d   = v_mem_q[idx_nxt];
          dp_w_d   = w_mem_q[idx_nxt];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      cap_v_q       <= '0;
      cap_w_q       <= '0;
      cap_spk_q     <= 1'b0;
      dp_req_q      <= 1'b0;
      dp_idx_q      <= '0;
      dp_v_q        <= '0;
      dp_w_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      spike_count_q <= '0;
      step_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      v_mem_q       <= '{default: '0};
      w_mem_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      cap_v_q       <= cap_v_d;
      cap_w_q       <= cap_w_d;
      cap_spk_q     <= cap_spk_d;
      dp_req_q      <= dp_req_d;
      dp_idx_q      <= dp_idx_d;
      dp_v_q        <= dp_v_d;
      dp_w_q        <= dp_w_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      spike_count_q <= spike_count_d;
      step_done_q   <= step_done_d;
      busy_q        <= busy_d;
      v_mem_q       <= v_mem_d;
      w_mem_q       <= w_mem_d;
    end
  end

  assign dp_req      = dp_req_q;
  assign dp_idx      = dp_idx_q;
  assign dp_v        = dp_v_q;
  assign dp_w        = dp_w_q;
  assign busy        = busy_q;
  assign step_done   = step_done_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Directed bench for izhikevich_scheduler: a cycle-level datapath responder
// with per-neuron ack delays and a bench-side model of neuron state.
module tb_izhikevich_scheduler;

  logic        clk = 1'b0;
  logic        rst, step_start, init_we, dp_ack, dp_spike;
  logic [2:0]  init_idx;
  logic [31:0] init_v, init_w, dp_new_v, dp_new_w;
  logic        dp_req, busy, step_done, spike_valid;
  logic [2:0]  dp_idx, spike_idx;
  logic [31:0] dp_v, dp_w;
  logic [3:0]  spike_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_v [8];
  logic [31:0] exp_w [8];
  int          delay_a [8];
  logic        spike_a [8];
  int          poke_cyc;
  int          abort_idx;
  logic        spur_ack;
  logic        co_init;
  logic [31:0] co_v, co_w;

  izhikevich_scheduler #(.N(32), .Q(16), .NUM_NEURONS(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .init_we(init_we),
    .init_idx(init_idx), .init_v(init_v), .init_w(init_w),
    .dp_req(dp_req), .dp_idx(dp_idx), .dp_v(dp_v), .dp_w(dp_w),
    .dp_ack(dp_ack), .dp_new_v(dp_new_v), .dp_new_w(dp_new_w), .dp_spike(dp_spike),
    .busy(busy), .step_done(step_done), .spike_valid(spike_valid),
    .spike_idx(spike_idx), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults(input int d);
    for (int i = 0; i < 8; i++) begin
      delay_a[i] = d;
      spike_a[i] = 1'b0;
    end
    poke_cyc  = -1;
    abort_idx = -1;
    spur_ack  = 1'b0;
    co_init   = 1'b0;
  endtask

  task automatic check_idle_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (busy !== 1'b0 || step_done !== 1'b0 || spike_valid !== 1'b0 || dp_req !== 1'b0)
        begin
        errors++;
        $display("FAIL %s: busy/done/sv/req got %b%b%b%b expected 0000", name,
                 busy, step_done, spike_valid, dp_req);
      end
      tick();
    end
  endtask

  // Runs one timestep; exp_len counts cycles from the first ISSUE cycle to DONE.
  task automatic run_step(input string name, input int exp_len, input int exp_spk);
    int cyc, cnt, exp_idx, nspk;
    logic done, aborted, wr_pend, pend_spk;
    logic [31:0] hold_v, hold_w;
    step_start = 1'b1;
    if (co_init) begin
      init_we = 1'b1; init_idx = 3'd0; init_v = co_v; init_w = co_w;
      exp_v[0] = co_v; exp_w[0] = co_w;
    end
    tick();
    step_start = 1'b0; init_we = 1'b0;
    cyc = 1; cnt = 0; exp_idx = 0; nspk = 0;
    done = 1'b0; aborted = 1'b0; wr_pend = 1'b0; pend_spk = 1'b0;
    hold_v = '0; hold_w = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_rise: got %b expected 1", name, busy);
    end
    while (!done && !aborted && cyc <= exp_len + 40) begin
      step_start = 1'b0; init_we = 1'b0; dp_ack = 1'b0; dp_spike = 1'b0;
      checks++;
      if (wr_pend) begin
        if (spike_valid !== pend_spk || dp_req !== 1'b0) begin
          errors++;
          $display("FAIL %s write_cycle idx %0d: spike_valid/dp_req got %b/%b expected %b/0",
                   name, exp_idx, spike_valid, dp_req, pend_spk);
        end
        if (pend_spk) begin
          nspk++;
          checks++;
          if (spike_idx !== 3'(exp_idx)) begin
            errors++; $display("FAIL %s spike_idx: got %0d expected %0d", name, spike_idx, exp_idx);
          end
        end
        exp_idx++; wr_pend = 1'b0;
      end else if (spike_valid !== 1'b0) begin
        errors++; $display("FAIL %s stray_spike cyc %0d: got 1 expected 0", name, cyc);
      end
      if (step_done) begin
        done = 1'b1;
        checks++;
        if (cyc != exp_len) begin
          errors++; $display("FAIL %s step_len: got %0d expected %0d", name, cyc, exp_len);
        end
        checks++;
        if (spike_count !== 4'(exp_spk)) begin
          errors++; $display("FAIL %s spike_count: got %0d expected %0d", name, spike_count, exp_spk);
        end
        checks++;
        if (exp_idx != 8 || nspk != exp_spk) begin
          errors++; $display("FAIL %s neurons/spikes: got %0d/%0d expected 8/%0d", name, exp_idx, nspk, exp_spk);
        end
      end else if (dp_req) begin
        cnt++;
        checks++;
        if (cnt == 1) begin
          if (dp_idx !== 3'(exp_idx) || dp_v !== exp_v[exp_idx] || dp_w !== exp_w[exp_idx]) begin
            errors++;
            $display("FAIL %s operands: got idx %0d v %h w %h expected idx %0d v %h w %h",
                     name, dp_idx, dp_v, dp_w, exp_idx, exp_v[exp_idx], exp_w[exp_idx]);
          end
          hold_v = dp_v; hold_w = dp_w;
        end else if (dp_idx !== 3'(exp_idx) || dp_v !== hold_v || dp_w !== hold_w) begin
          errors++;
          $display("FAIL %s hold: got idx %0d v %h w %h expected idx %0d v %h w %h",
                   name, dp_idx, dp_v, dp_w, exp_idx, hold_v, hold_w);
        end
        if (exp_idx == abort_idx && cnt == 3) aborted = 1'b1;
        else if (cnt == delay_a[exp_idx] + 2) begin
          dp_ack   = 1'b1;
          dp_new_v = exp_v[exp_idx] + 32'h0001_0000;
          dp_new_w = exp_w[exp_idx] + 32'(exp_idx + 1);
          dp_spike = spike_a[exp_idx];
          exp_v[exp_idx] = dp_new_v;
          exp_w[exp_idx] = dp_new_w;
          pend_spk = spike_a[exp_idx];
          wr_pend = 1'b1; cnt = 0;
        end
      end else if (spur_ack) begin
        dp_ack = 1'b1; dp_spike = 1'b1; dp_new_v = 32'hDEAD_BEEF; dp_new_w = 32'hBAD0_F00D;
      end
      if (cyc == poke_cyc) begin
        step_start = 1'b1; init_we = 1'b1; init_idx = 3'd0;
        init_v = 32'h1234_5678; init_w = 32'h8765_4321;
      end
      if (!aborted) begin
        tick();
        cyc++;
      end
    end
    dp_ack = 1'b0; dp_spike = 1'b0; step_start = 1'b0; init_we = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dp_req !== 1'b0 || busy !== 1'b0 || step_done !== 1'b0 || spike_valid !== 1'b0 ||
          spike_idx !== 3'd0 || dp_idx !== 3'd0 || dp_v !== 32'd0 || dp_w !== 32'd0 ||
          spike_count !== 4'd0) begin
        errors++;
        $display("FAIL %s abort_outputs: got req%b busy%b done%b sv%b sidx%0d idx%0d v%h w%h cnt%0d expected all 0",
                 name, dp_req, busy, step_done, spike_valid, spike_idx, dp_idx, dp_v, dp_w, spike_count);
      end
      for (int i = 0; i < 8; i++) begin
        exp_v[i] = '0; exp_w[i] = '0;
      end
      check_idle_quiet({name, "_post_abort"}, 6);
    end else begin
      checks++;
      if (!done) begin
        errors++; $display("FAIL %s timeout: got no step_done expected one at cycle %0d", name, exp_len);
      end
      tick();
      check_idle_quiet({name, "_after"}, 4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step_start = 1'b0; init_we = 1'b0; init_idx = '0; init_v = '0; init_w = '0;
    dp_ack = 1'b0; dp_spike = 1'b0; dp_new_v = '0; dp_new_w = '0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({dp_req, busy, step_done, spike_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {dp_req, busy, step_done, spike_valid});
    end
    checks++;
    if (dp_idx !== 3'd0 || spike_idx !== 3'd0 || spike_count !== 4'd0) begin
      errors++; $display("FAIL reset_idx: got %0d/%0d/%0d expected 0/0/0", dp_idx, spike_idx, spike_count);
    end
    checks++;
    if (dp_v !== 32'd0 || dp_w !== 32'd0) begin
      errors++; $display("FAIL reset_operands: got %h/%h expected 0/0", dp_v, dp_w);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < 8; i++) begin
      init_we = 1'b1; init_idx = 3'(i); init_v = 32'hFFBF_0000; init_w = 32'd0;
      exp_v[i] = 32'hFFBF_0000; exp_w[i] = 32'd0;
      tick();
    end
    init_we = 1'b0;
  endtask

  task automatic test_basic_step();
    set_defaults(1);
    run_step("basic", 33, 0);
    set_defaults(1);
    run_step("basic_readback", 33, 0);
  endtask

  task automatic test_spikes();
    set_defaults(1);
    spike_a[2] = 1'b1; spike_a[7] = 1'b1;
    run_step("spikes", 33, 2);
  endtask

  task automatic test_slow_ack();
    set_defaults(1);
    delay_a[4] = 5;
    run_step("slow_ack", 37, 0);
  endtask

  task automatic test_busy_ignore();
    set_defaults(1);
    poke_cyc = 10;
    run_step("busy_ignore", 33, 0);
  endtask

  task automatic test_spurious_ack();
    for (int i = 0; i < 3; i++) begin
      dp_ack = 1'b1; dp_spike = 1'b1; dp_new_v = 32'hDEAD_BEEF; dp_new_w = 32'hBAD0_F00D;
      tick();
      checks++;
      if ({busy, spike_valid, step_done, dp_req} !== 4'b0000) begin
        errors++; $display("FAIL spur_idle: got %b expected 0000", {busy, spike_valid, step_done, dp_req});
      end
    end
    dp_ack = 1'b0; dp_spike = 1'b0;
    set_defaults(0);
    spur_ack = 1'b1;
    run_step("spurious_ack", 25, 0);
  endtask

  task automatic test_init_with_start();
    set_defaults(0);
    co_init = 1'b1; co_v = 32'h0000_0100; co_w = 32'h0000_0007;
    spike_a[5] = 1'b1;
    run_step("init_with_start", 25, 1);
  endtask

  task automatic test_reset_mid_step();
    set_defaults(1);
    delay_a[3] = 20;
    abort_idx = 3;
    run_step("abort", 100, 0);
    set_defaults(1);
    run_step("after_abort", 33, 0);
  endtask

  task automatic test_back_to_back();
    set_defaults(0);
    spike_a[0] = 1'b1;
    run_step("b2b_first", 25, 1);
    set_defaults(2);
    run_step("b2b_second", 41, 0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic_step();
    test_spikes();
    test_slow_ack();
    test_busy_ignore();
    test_spurious_ack();
    test_init_with_start();
    test_reset_mid_step();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/izhikevich_scheduler.md
IZHIKEVICH_SCHEDULER -- requirements
Module: izhikevich_scheduler

Interface
REQ-001 Parameter N, default 32, fixed-point word width in bits.
REQ-002 Parameter Q, default 16, fractional bits; carried for datapath consistency, no arithmetic performed here.
REQ-003 Parameter NUM_NEURONS, default 8, number of time-multiplexed neurons, range 2..256.
REQ-004 Parameter IDX_W, default 3, index width, equal to clog2(NUM_NEURONS).
REQ-005 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 step_start  input  1  single-cycle request to run one timestep over all neurons.
REQ-009 init_we  input  1  write initial state for neuron init_idx.
REQ-010 init_idx  input  IDX_W  neuron index for init write.
REQ-011 init_v  input  N  initial voltage.
REQ-012 init_w  input  N  initial recovery variable.
REQ-013 dp_req  output  1  request to shared update datapath, operands valid.
REQ-014 dp_idx  output  IDX_W  neuron index under update.
REQ-015 dp_v  output  N  voltage operand.
REQ-016 dp_w  output  N  recovery operand.
REQ-017 dp_ack  input  1  datapath result valid; consumed only while dp_req high.
REQ-018 dp_new_v  input  N  updated voltage (post-reset-to-c if spiked).
REQ-019 dp_new_w  input  N  updated recovery (post-add-d if spiked).
REQ-020 dp_spike  input  1  threshold crossed for this update.
REQ-021 busy  output  1  high from accepted step_start through step_done cycle.
REQ-022 step_done  output  1  single-cycle pulse, timestep complete.
REQ-023 spike_valid  output  1  single-cycle pulse per spiking neuron.
REQ-024 spike_idx  output  IDX_W  index of spiking neuron, valid with spike_valid.
REQ-025 spike_count  output  IDX_W+1  spikes in last completed timestep, updated with step_done.

Function
REQ-026 Internal state arrays v_mem[NUM_NEURONS], w_mem[NUM_NEURONS] of N bits SHALL hold per-neuron state.
REQ-027 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-028 IDLE: step_start -> ISSUE next cycle, idx cleared to 0, running spike counter cleared; busy rises same edge.
REQ-029 ISSUE: drive dp_req=1, dp_idx=idx, dp_v=v_mem[idx], dp_w=w_mem[idx]; go to WAIT.
REQ-030 WAIT: dp_req held high, operands stable, until dp_ack=1; dp_ack may arrive the first WAIT cycle (minimum one cycle after ISSUE); no timeout.
REQ-031 On dp_ack in WAIT: capture dp_new_v/dp_new_w/dp_spike, drop dp_req next cycle, go to WRITE.
REQ-032 WRITE: commit captured values to v_mem[idx]/w_mem[idx]; if captured spike, pulse spike_valid with spike_idx=idx and increment counter.
REQ-033 WRITE: if idx==NUM_NEURONS-1 go to DONE, else idx+1 and go to ISSUE; idx never wraps mid-step.
REQ-034 DONE: pulse step_done for one cycle, load spike_count from counter, return to IDLE; busy low the following cycle.
REQ-035 Per-neuron latency SHALL be 3 cycles plus datapath wait; full step = NUM_NEURONS*(3+ack delay)+1 cycles.
REQ-036 step_start while busy SHALL be ignored (not queued).
REQ-037 init_we SHALL write only in IDLE; init_we while busy ignored; init_we with step_start same IDLE cycle: write occurs, step starts, neuron state read in ISSUE reflects the write.
REQ-038 dp_ack outside WAIT SHALL be ignored.
REQ-039 spike_count saturates at NUM_NEURONS (cannot exceed by construction; width holds it).

Reset
REQ-040 rst SHALL return FSM to IDLE and force dp_req=0, busy=0, step_done=0, spike_valid=0, spike_idx=0, dp_idx=0, dp_v=0, dp_w=0, spike_count=0.
REQ-041 rst SHALL clear v_mem and w_mem to 0; rst mid-step aborts without any further write, step_done not issued.

Verification
REQ-042 Init all 8 neurons v=0xFFBF0000 (-65.0), w=0; step_start; ack each after 1 cycle, new_v=v+0x00010000, no spike -> 8 requests idx 0..7, step_done at cycle 33, v_mem all 0xFFC00000, spike_count=0.
REQ-043 dp_spike=1 on idx 2 and 7 -> spike_valid pulses with spike_idx 2 then 7, spike_count=2 at step_done.
REQ-044 ack delay 5 cycles on idx 4, 0 extra elsewhere -> dp_req and operands held stable through WAIT, step length +4 cycles.
REQ-045 step_start and init_we pulsed mid-step -> no restart, no memory change, only one step_done.
REQ-046 rst asserted while WAIT on idx 3 -> next cycle all outputs 0, FSM IDLE, memory zero; subsequent step_start runs full 8-neuron sequence.
REQ-047 Spurious dp_ack in IDLE and WRITE -> no state change, no spike.
